// File: rtl/mbist_resp_checker.sv
// MBIST read-response checker: compares memory read data with the expectation issued rd_latency cycles earlier.
// Results update one edge after the compare; reads are accepted every cycle, no backpressure.
module mbist_resp_checker #(
  parameter int length     = 4,
  parameter int data_width = 8,
  parameter int rd_latency = 1,
  parameter int cnt_width  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  rd_en,
  input  logic [length-1:0]     addr,
  input  logic [data_width-1:0] exp_data,
  input  logic                  last,
  input  logic [data_width-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [cnt_width-1:0]  fail_count,
  output logic [length-1:0]     first_fail_addr,
  output logic [data_width-1:0] first_syndrome,
  output logic [data_width-1:0] bitmap
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state, state_nxt;

  logic [rd_latency-1:0] pipe_vld;
  logic [length-1:0]     pipe_addr [rd_latency];
  logic [data_width-1:0] pipe_exp  [rd_latency];

  logic                  start_ok;
  logic                  accept;
  logic                  ret_vld;
  logic [data_width-1:0] syn;
  logic                  mismatch;

  assign start_ok = start && (state == IDLE || state == DONE);
  assign accept   = rd_en && (state == RUN);
  assign ret_vld  = pipe_vld[rd_latency-1];
  assign syn      = rd_data ^ pipe_exp[rd_latency-1];
  assign mismatch = ret_vld && (syn != '0);

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DRAIN;
      // nothing enters the pipeline outside RUN, so an all-clear valid vector means empty
      DRAIN:   if (pipe_vld == '0) state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      for (int i = 0; i < rd_latency; i++) begin
        pipe_addr[i] <= '0;
        pipe_exp[i]  <= '0;
      end
    end else begin
      pipe_vld[0]  <= accept;
      pipe_addr[0] <= addr;
      pipe_exp[0]  <= exp_data;
      for (int i = 1; i < rd_latency; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_addr[i] <= pipe_addr[i-1];
        pipe_exp[i]  <= pipe_exp[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail            <= 1'b0;
      fail_count      <= '0;
      first_fail_addr <= '0;
      first_syndrome  <= '0;
      bitmap          <= '0;
    end else if (start_ok) begin
      fail            <= 1'b0;
      fail_count      <= '0;
      first_fail_addr <= '0;
      first_syndrome  <= '0;
      bitmap          <= '0;
    end else if (mismatch) begin
      fail   <= 1'b1;
      bitmap <= bitmap | syn;
      if (fail_count != '1) begin
        fail_count <= fail_count + 1'b1;
      end
      // first_* capture only on the first mismatch of the session
      if (!fail) begin
        first_fail_addr <= pipe_addr[rd_latency-1];
        first_syndrome  <= syn;
      end
    end
  end

endmodule
